// File: rtl/io_input_conditioner.sv
// Input-bank front end: synchronises switches, debounces buttons, and keeps
// sticky press flags that software clears with a one-cycle ack strobe.
module io_input_conditioner #(
    parameter int NSW            = 32,
    parameter int NBTN           = 4,
    parameter int DB_CYCLES      = 20000,
    parameter int CNT_W          = 16,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NSW-1:0]  i_sw_raw,
    input  logic [NBTN-1:0] i_btn_raw,
    input  logic            i_ack,
    input  logic [NBTN-1:0] i_ack_mask,
    output logic [NSW-1:0]  o_io_sw,
    output logic [NBTN-1:0] o_io_btn,
    output logic [NBTN-1:0] o_btn_flag,
    output logic            o_btn_irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [NSW-1:0]   sw_meta;
    logic [NBTN-1:0]  btn_pol;
    logic [NBTN-1:0]  btn_meta;
    logic [NBTN-1:0]  btn_sync;
    logic [NBTN-1:0]  btn_state_next;
    logic [NBTN-1:0]  press;
    logic [NBTN-1:0]  flag_next;
    logic [CNT_W-1:0] cnt      [NBTN];
    logic [CNT_W-1:0] cnt_next [NBTN];

    // Polarity is corrected before the synchroniser so everything downstream
    // (including the reset level of the sync flops) reads 1 = pressed.
    assign btn_pol = (BTN_ACTIVE_LOW != 0) ? ~i_btn_raw : i_btn_raw;

    always_comb begin
        btn_state_next = o_io_btn;
        for (int i = 0; i < NBTN; i++) begin
            cnt_next[i] = '0;
            if (btn_sync[i] != o_io_btn[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    btn_state_next[i] = btn_sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
        press = btn_state_next & ~o_io_btn;

        // i_ack is a single-cycle strobe with no back-pressure: on any edge
        // where it is high, flags selected by i_ack_mask clear, unless a new
        // press on the same bit lands on that edge, in which case set wins.
        flag_next = o_btn_flag;
        if (i_ack) begin
            flag_next = flag_next & ~i_ack_mask;
        end
        flag_next = flag_next | press;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_meta    <= '0;
            o_io_sw    <= '0;
            btn_meta   <= '0;
            btn_sync   <= '0;
            o_io_btn   <= '0;
            o_btn_flag <= '0;
            o_btn_irq  <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_meta    <= i_sw_raw;
            o_io_sw    <= sw_meta;
            btn_meta   <= btn_pol;
            btn_sync   <= btn_meta;
            o_io_btn   <= btn_state_next;
            o_btn_flag <= flag_next;
            o_btn_irq  <= |flag_next;
            for (int i = 0; i < NBTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios with literal checks, then
// random stimulus compared every cycle against a window-based reference model.
module tb_io_input_conditioner;

    localparam int NSW   = 32;
    localparam int NBTN  = 4;
    localparam int DB    = 4;
    localparam int CNT_W = 4;
    localparam int BAL   = 1;
    localparam int W     = NSW + 2*NBTN + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSW-1:0]  sw_raw;
    logic [NBTN-1:0] btn_raw;
    logic            ack;
    logic [NBTN-1:0] ack_mask;
    logic [NSW-1:0]  io_sw;
    logic [NBTN-1:0] io_btn;
    logic [NBTN-1:0] btn_flag;
    logic            btn_irq;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    io_input_conditioner #(
        .NSW(NSW), .NBTN(NBTN), .DB_CYCLES(DB), .CNT_W(CNT_W), .BTN_ACTIVE_LOW(BAL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sw_raw(sw_raw),
        .i_btn_raw(btn_raw),
        .i_ack(ack),
        .i_ack_mask(ack_mask),
        .o_io_sw(io_sw),
        .o_io_btn(io_btn),
        .o_btn_flag(btn_flag),
        .o_btn_irq(btn_irq)
    );

    // Reference model: 2-deep pipelines as plain variables, and a window of the
    // last DB synchronised samples per button; the stable level flips once all
    // DB samples in a full window disagree with it.
    logic [NSW-1:0]  m_sw1, m_sw2;
    logic [NBTN-1:0] m_s1, m_s2, m_b, m_f;
    logic [DB-1:0]   hist [NBTN];
    logic [DB-1:0]   hv   [NBTN];

    task automatic model_step();
        logic [NBTN-1:0] press;
        press = '0;
        if (rst) begin
            m_sw1 = '0; m_sw2 = '0; m_s1 = '0; m_s2 = '0; m_b = '0; m_f = '0;
            for (int i = 0; i < NBTN; i++) begin
                hist[i] = '0;
                hv[i]   = '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                hist[i] = {hist[i][DB-2:0], m_s2[i]};
                hv[i]   = {hv[i][DB-2:0], 1'b1};
                if ((&hv[i]) && (hist[i] == {DB{~m_b[i]}})) begin
                    press[i] = ~m_b[i];
                    m_b[i]   = ~m_b[i];
                end
            end
            if (ack) m_f = m_f & ~ack_mask;
            m_f = m_f | press;
            m_s2  = m_s1;
            m_s1  = (BAL != 0) ? ~btn_raw : btn_raw;
            m_sw2 = m_sw1;
            m_sw1 = sw_raw;
        end
        exp_q.push_back({m_sw2, m_b, m_f, |m_f});
    endtask

    always @(posedge clk) model_step();

    function automatic logic [W-1:0] dut_out();
        return {io_sw, io_btn, btn_flag, btn_irq};
    endfunction

    // scoreboard: one compare per cycle against the model's expected queue
    task automatic compare_step();
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = dut_out();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
        end
    endtask

    always @(negedge clk) compare_step();

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse_ack(input logic [NBTN-1:0] mask);
        ack      = 1'b1;
        ack_mask = mask;
        tick(1);
        ack      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; ack_mask = '0; sw_raw = '1; btn_raw = '0;
        @(negedge clk);
        repeat (3) begin
            tick(1);
            check_lit("reset_outputs", 64'(dut_out()), 64'h0);
        end
        btn_raw = 4'hF; sw_raw = '0; rst = 1'b0;
        tick(8);
        check_lit("idle_after_reset", 64'(dut_out()), 64'h0);

        sw_raw = 32'h33221100;
        tick(1);
        check_lit("sw_one_edge", 64'(io_sw), 64'h0);
        tick(1);
        check_lit("sw_two_edges", 64'(io_sw), 64'h33221100);

        btn_raw = 4'hE;
        tick(5);
        check_lit("press_early_btn", 64'(io_btn), 64'h0);
        tick(1);
        check_lit("press_btn", 64'(io_btn), 64'h1);
        check_lit("press_flag", 64'(btn_flag), 64'h1);
        check_lit("press_irq", 64'(btn_irq), 64'h1);

        btn_raw = 4'hC; tick(3);
        btn_raw = 4'hE; tick(1);
        btn_raw = 4'hC;
        tick(5);
        check_lit("bounce_early_btn", 64'(io_btn), 64'h1);
        tick(1);
        check_lit("bounce_btn", 64'(io_btn), 64'h3);
        check_lit("bounce_flag", 64'(btn_flag), 64'h3);

        btn_raw = 4'h4;
        tick(8);
        check_lit("flags_b", 64'(btn_flag), 64'hB);
        pulse_ack(4'h3);
        check_lit("ack3_flag", 64'(btn_flag), 64'h8);
        check_lit("ack3_irq", 64'(btn_irq), 64'h1);
        pulse_ack(4'h8);
        check_lit("ack8_flag", 64'(btn_flag), 64'h0);
        check_lit("ack8_irq", 64'(btn_irq), 64'h0);

        btn_raw = 4'h5;
        tick(8);
        check_lit("release_btn", 64'(io_btn), 64'hA);
        check_lit("release_no_flag", 64'(btn_flag), 64'h0);
        btn_raw = 4'h4;
        tick(5);
        pulse_ack(4'h1);
        check_lit("collide_flag", 64'(btn_flag), 64'h1);
        check_lit("collide_btn", 64'(io_btn), 64'hB);

        btn_raw = 4'h5;
        tick(8);
        pulse_ack(4'hF);
        check_lit("clear_all", 64'(btn_flag), 64'h0);
        btn_raw = 4'h4;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_lit("midreset_btn", 64'(io_btn), 64'h0);
        check_lit("midreset_flag", 64'(btn_flag), 64'h0);
        tick(5);
        check_lit("after_reset_early", 64'(io_btn), 64'h0);
        tick(1);
        check_lit("after_reset_btn", 64'(io_btn), 64'hB);
        check_lit("after_reset_flag", 64'(btn_flag), 64'hB);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NBTN; i++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
            end
            if ($urandom_range(0, 15) == 0) sw_raw = $urandom();
            ack      = ($urandom_range(0, 7) == 0);
            ack_mask = 4'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0; ack = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
